// File: rtl/i2c_init_seq.sv
// Table-driven codec register initialiser: walks an external lookup table and
// issues one single-register write per entry, with NACK retry and a watchdog.
module i2c_init_seq #(
  parameter logic [7:0] DEVICE_ID   = 8'h20,
  parameter logic       ADDR_MODE   = 1'b0,
  parameter int         LUT_SIZE    = 32,
  parameter int         IDX_W       = 5,
  parameter int         POWERUP_DLY = 1000,
  parameter int         GAP_DLY     = 4,
  parameter int         DELAY_UNIT  = 1000,
  parameter int         MAX_RETRY   = 3,
  parameter int         TIMEOUT     = 200000
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  output logic [IDX_W-1:0] lut_index,
  input  logic [23:0]      lut_data,
  output logic             wrreg_req,
  output logic             rdreg_req,
  output logic [15:0]      addr,
  output logic             addr_mode,
  output logic [7:0]       wrdata,
  output logic [7:0]       device_id,
  input  logic             RW_Done,
  input  logic             ack,
  output logic             busy,
  output logic             init_done,
  output logic             init_err,
  output logic [IDX_W-1:0] err_index
);

  localparam logic [3:0] PWR_WAIT  = 4'd0;
  localparam logic [3:0] FETCH     = 4'd1;
  localparam logic [3:0] LATCH     = 4'd2;
  localparam logic [3:0] ISSUE     = 4'd3;
  localparam logic [3:0] WAIT_DONE = 4'd4;
  localparam logic [3:0] GAP       = 4'd5;
  localparam logic [3:0] DELAY     = 4'd6;
  localparam logic [3:0] DONE      = 4'd7;
  localparam logic [3:0] ERROR     = 4'd8;

  localparam int               GAP_EFF  = (GAP_DLY < 1) ? 1 : GAP_DLY;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_SIZE - 1);

  logic [3:0]       state;
  logic [IDX_W-1:0] idx;
  logic [31:0]      cnt;
  logic [7:0]       retry;
  logic             gap_reissue;
  logic             at_last;

  assign lut_index = idx;
  assign wrreg_req = (state == ISSUE);
  assign rdreg_req = 1'b0;
  assign addr_mode = ADDR_MODE;
  assign device_id = DEVICE_ID;
  assign busy      = (state != DONE) && (state != ERROR);
  assign init_done = (state == DONE);
  assign init_err  = (state == ERROR);
  assign at_last   = (idx == LAST_IDX);

  // One shared counter serves as power-up timer, gap timer, delay-entry
  // countdown and write watchdog, since only one is ever active at a time.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= PWR_WAIT;
      idx         <= '0;
      cnt         <= '0;
      retry       <= '0;
      gap_reissue <= 1'b0;
      addr        <= '0;
      wrdata      <= '0;
      err_index   <= '0;
    end else begin
      case (state)
        PWR_WAIT: begin
          if (cnt + 32'd1 >= 32'(POWERUP_DLY)) begin
            state <= FETCH;
            idx   <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          if (lut_data[23:8] == 16'hFFFF) begin
            state <= DELAY;
            cnt   <= 32'(lut_data[7:0]) * 32'(DELAY_UNIT);
          end else begin
            addr   <= lut_data[23:8];
            wrdata <= lut_data[7:0];
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_DONE;
          cnt   <= '0;
        end
        WAIT_DONE: begin
          if (RW_Done && !ack) begin
            retry <= '0;
            if (at_last) begin
              state <= DONE;
            end else begin
              idx         <= idx + 1'b1;
              gap_reissue <= 1'b0;
              cnt         <= '0;
              state       <= GAP;
            end
          end else if (RW_Done) begin
            retry <= retry + 8'd1;
            if ({24'd0, retry} + 32'd1 < 32'(MAX_RETRY)) begin
              gap_reissue <= 1'b1;
              cnt         <= '0;
              state       <= GAP;
            end else begin
              err_index <= idx;
              state     <= ERROR;
            end
          end else if (cnt + 32'd1 >= 32'(TIMEOUT)) begin
            err_index <= idx;
            state     <= ERROR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GAP: begin
          if (cnt + 32'd1 >= 32'(GAP_EFF)) begin
            state <= gap_reissue ? ISSUE : FETCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DELAY: begin
          if (cnt == 32'd0) begin
            if (at_last) begin
              state <= DONE;
            end else begin
              idx         <= idx + 1'b1;
              gap_reissue <= 1'b0;
              state       <= GAP;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DONE, ERROR: begin
          if (start) begin
            idx       <= '0;
            retry     <= '0;
            err_index <= '0;
            cnt       <= '0;
            state     <= FETCH;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Randomized self-checking bench for i2c_init_seq: a behavioural controller
// model answers requests and an entry-level model predicts the write stream.
module tb_i2c_init_seq;

  localparam int         LUT_SIZE    = 4;
  localparam int         IDX_W       = 2;
  localparam int         POWERUP_DLY = 10;
  localparam int         GAP_DLY     = 2;
  localparam int         DELAY_UNIT  = 5;
  localparam int         MAX_RETRY   = 3;
  localparam int         TIMEOUT     = 50;
  localparam logic [7:0] DEV         = 8'h34;
  localparam logic       AMODE       = 1'b1;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] lut_index;
  logic [23:0]      lut_data;
  logic             wrreg_req, rdreg_req, addr_mode;
  logic [15:0]      addr;
  logic [7:0]       wrdata, device_id;
  logic             RW_Done, ack;
  logic             busy, init_done, init_err;
  logic [IDX_W-1:0] err_index;

  logic [23:0] lut_tbl [LUT_SIZE];
  int          nack_cnt [LUT_SIZE];
  bit          hang [LUT_SIZE];
  int          attempts [LUT_SIZE];
  int          done_cyc [LUT_SIZE];
  logic [23:0] seen_q [$];
  int          req_cyc_q [$];
  int          req_ent_q [$];
  logic [23:0] exp_q [$];
  bit          exp_err;
  int          exp_eidx;
  int          cyc = 0, rel_cyc = 0, end_cyc = 0;
  int          pend = 0, pend_ent = 0, fixed_lat = 0, start_pulse_at = -1;
  bit          pend_ack = 1'b0;
  int          n_checks = 0, n_errors = 0;

  assign lut_data = lut_tbl[lut_index];

  i2c_init_seq #(
    .DEVICE_ID(DEV), .ADDR_MODE(AMODE), .LUT_SIZE(LUT_SIZE), .IDX_W(IDX_W),
    .POWERUP_DLY(POWERUP_DLY), .GAP_DLY(GAP_DLY), .DELAY_UNIT(DELAY_UNIT),
    .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .lut_index(lut_index),
    .lut_data(lut_data), .wrreg_req(wrreg_req), .rdreg_req(rdreg_req),
    .addr(addr), .addr_mode(addr_mode), .wrdata(wrdata), .device_id(device_id),
    .RW_Done(RW_Done), .ack(ack), .busy(busy), .init_done(init_done),
    .init_err(init_err), .err_index(err_index)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int find_entry(logic [15:0] a);
    for (int i = 0; i < LUT_SIZE; i++)
      if (a != 16'hFFFF && lut_tbl[i][23:8] == a) return i;
    return -1;
  endfunction

  // Controller model: logs every request and answers after a latency, NACKing
  // the first nack_cnt[e] attempts of entry e, or never answering if hung.
  always @(negedge Clk) begin
    int e;
    RW_Done = 1'b0;
    ack     = 1'b0;
    if (!Rst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          RW_Done = 1'b1;
          ack     = pend_ack;
          done_cyc[pend_ent] = cyc;
        end
      end
      if (wrreg_req) begin
        e = find_entry(addr);
        seen_q.push_back({addr, wrdata});
        req_cyc_q.push_back(cyc);
        req_ent_q.push_back(e);
        if (e >= 0) begin
          attempts[e]++;
          if (!hang[e]) begin
            pend     = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 20));
            pend_ack = (attempts[e] <= nack_cnt[e]);
            pend_ent = e;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  // Entry-level model: each real entry is written until acked or MAX_RETRY
  // attempts are used; delay entries produce no writes; a hang aborts at once.
  task automatic build_model();
    exp_q.delete();
    exp_err  = 1'b0;
    exp_eidx = 0;
    for (int e = 0; e < LUT_SIZE; e++) begin
      if (lut_tbl[e][23:8] == 16'hFFFF) continue;
      if (hang[e]) begin
        exp_q.push_back(lut_tbl[e]);
        exp_err = 1'b1; exp_eidx = e;
        return;
      end
      for (int a = 0; a < MAX_RETRY && a <= nack_cnt[e]; a++) exp_q.push_back(lut_tbl[e]);
      if (nack_cnt[e] >= MAX_RETRY) begin
        exp_err = 1'b1; exp_eidx = e;
        return;
      end
    end
  endtask

  task automatic clear_log();
    seen_q.delete(); req_cyc_q.delete(); req_ent_q.delete();
    for (int i = 0; i < LUT_SIZE; i++) begin
      attempts[i] = 0;
      done_cyc[i] = -1;
    end
  endtask

  task automatic random_table(input int delay_pct);
    logic [13:0] hi;
    for (int i = 0; i < LUT_SIZE; i++) begin
      hi = 14'($urandom_range(0, 14'h3FFE));
      if (int'($urandom_range(0, 99)) < delay_pct) lut_tbl[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
      else lut_tbl[i] = {hi, 2'(i), 8'($urandom)};
      nack_cnt[i] = 0;
      hang[i]     = 1'b0;
    end
    fixed_lat      = 0;
    start_pulse_at = -1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    repeat (2) tick();
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_wrreg", wrreg_req, 0);
    checkOutput("rst_done", init_done, 0);
    checkOutput("rst_err", init_err, 0);
    checkOutput("rst_err_index", err_index, 0);
    checkOutput("rst_lut_index", lut_index, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_wrdata", wrdata, 0);
    checkOutput("rdreg_req", rdreg_req, 0);
    checkOutput("addr_mode", addr_mode, AMODE);
    checkOutput("device_id", device_id, DEV);
    clear_log();
    Rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(init_done || init_err) && n < 3000) begin
      tick();
      n++;
      start = (n == start_pulse_at);
    end
    start   = 1'b0;
    end_cyc = cyc;
    checkOutput("end_reached", init_done | init_err, 1);
  endtask

  task automatic compare_run();
    checkOutput("req_count", seen_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < seen_q.size(); k++)
      checkOutput($sformatf("req%0d", k), seen_q[k], exp_q[k]);
    checkOutput("init_done", init_done, {31'd0, !exp_err});
    checkOutput("init_err", init_err, {31'd0, exp_err});
    checkOutput("busy_end", busy, 0);
    if (exp_err) checkOutput("err_index", err_index, exp_eidx);
  endtask

  task automatic finish_run();
    int d;
    wait_end();
    compare_run();
    if (seen_q.size() > 0 && lut_tbl[0][23:8] != 16'hFFFF) begin
      d = req_cyc_q[0] - rel_cyc;
      checkOutput("first_req_latency", d, (d >= 10 && d <= 13) ? d : 32'hFFFF_FFFF);
    end
  endtask

  task automatic applyStimulus(input string name);
    $display("[TB] scenario %s", name);
    build_model();
    do_reset();
    finish_run();
  endtask

  initial begin
    int k, d;

    random_table(0);
    lut_tbl[0] = {16'h0000, 8'h80};
    lut_tbl[1] = {16'h0001, 8'h50};
    lut_tbl[2] = {16'h0002, 8'h00};
    lut_tbl[3] = {16'h0008, 8'h00};
    fixed_lat      = 20;
    start_pulse_at = 40;
    applyStimulus("nominal");

    random_table(0);
    lut_tbl[1] = {16'hFFFF, 8'h03};
    applyStimulus("delay");
    k = -1;
    foreach (req_ent_q[i]) if (k < 0 && req_ent_q[i] == 2) k = i;
    d = (k >= 0) ? req_cyc_q[k] - done_cyc[0] : -1;
    checkOutput("delay_gap", (d >= 15) ? 1 : 0, 1);

    random_table(0);
    nack_cnt[2] = 2;
    applyStimulus("nack_retry");
    checkOutput("retry_attempts", attempts[2], 3);

    random_table(0);
    nack_cnt[1] = 9;
    applyStimulus("abort");
    checkOutput("abort_attempts1", attempts[1], 3);
    checkOutput("abort_attempts2", attempts[2], 0);
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("restart_err_clr", init_err, 0);
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_err_index", err_index, 0);
    wait_end();
    compare_run();

    random_table(0);
    hang[0] = 1'b1;
    applyStimulus("timeout");
    d = (req_cyc_q.size() > 0) ? end_cyc - req_cyc_q[0] : -1;
    checkOutput("timeout_latency", d, (d >= 50 && d <= 52) ? d : 32'hFFFF_FFFF);

    random_table(0);
    fixed_lat = 20;
    build_model();
    do_reset();
    k = 0;
    while (attempts[2] == 0 && k < 1000) begin
      tick();
      k++;
    end
    checkOutput("reached_entry2", (attempts[2] > 0) ? 1 : 0, 1);
    repeat (3) tick();
    Rst_n = 1'b0;
    #1;
    checkOutput("midrst_wrreg", wrreg_req, 0);
    checkOutput("midrst_done", init_done, 0);
    checkOutput("midrst_err", init_err, 0);
    checkOutput("midrst_busy", busy, 1);
    repeat (2) tick();
    clear_log();
    Rst_n   = 1'b1;
    rel_cyc = cyc;
    finish_run();

    for (int it = 0; it < 6; it++) begin
      random_table(25);
      for (int i = 0; i < LUT_SIZE; i++)
        nack_cnt[i] = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3)) : 0;
      applyStimulus($sformatf("random%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
